riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//   Shares the single-port data BRAM between two requesters: instruction fetch (IF, read-only)
//   and the load/store unit (D, read/write, byte lanes pre-formatted by the memory interface).
//   It sits between those requesters and the BRAM and sequences each access.
//   Access sequencing covers grant, address/write-strobe drive, read-latency wait and response.
//   One access in flight at a time. D has priority, with a starvation guard for IF.
// PARAMETERS
//   READ_LATENCY  2  BRAM cycles from mem_addr_out change to valid mem_data_in (>=1)
//   STARVE_LIMIT  4  max consecutive D grants while IF waits before IF is forced (>=1)
// PORTS
//   clk_in                in   1   clock
//   rst_n_in              in   1   async active-low reset
//   if_req_in             in   1   IF read request; hold with if_addr_in stable until ack
//   if_addr_in            in   32  IF word address
//   if_ack_out            out  1   IF request accepted this cycle
//   if_rvalid_out         out  1   IF read data valid (1-cycle pulse)
//   if_rdata_out          out  32  IF read data; 0 when if_rvalid_out low
//   d_req_in              in   1   D request; hold with addr/we/wdata/be stable until ack
//   d_we_in               in   1   1 = write, 0 = read
//   d_addr_in             in   32  D address
//   d_wdata_in            in   32  D write data, already lane-aligned
//   d_be_in               in   4   D byte-lane write enables
//   d_ack_out             out  1   D request accepted this cycle
//   d_rvalid_out          out  1   D read data valid (1-cycle pulse)
//   d_rdata_out           out  32  D raw read word; 0 when d_rvalid_out low
//   mem_addr_out          out  32  BRAM address (registered)
//   mem_data_out          out  32  BRAM write data (registered)
//   mem_write_enable_out  out  4   BRAM byte write enables (registered)
//   mem_data_in           in   32  BRAM read data
//   busy_out              out  1   state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n_in=0)
//     - Immediately: state=IDLE, cnt=0, streak=0.
//     - All outputs 0, including mem_addr_out.
//     - An in-flight access is dropped: no rvalid after release; the requester must re-request.
//   FSM states: IDLE, READ, WRITE
//     IDLE, grant in cycle T
//       - Combinational ack_out=1 for the winner only.
//       - At edge T: mem_addr_out<=addr.
//       - Read: cnt<=READ_LATENCY, go to READ.
//       - Write: mem_data_out<=wdata, mem_write_enable_out<=be, go to WRITE.
//     READ
//       - cnt decrements each cycle.
//       - When cnt==0: owner rvalid=1, rdata=mem_data_in (combinational), next state IDLE.
//       - rvalid lands in cycle T+1+READ_LATENCY.
//     WRITE
//       - Strobes are live exactly one cycle (T+1).
//       - Next state IDLE; mem_write_enable_out<=0, mem_data_out<=0.
//       - No rvalid for writes.
//       - d_be_in==0 still runs the full WRITE cycle, with no lanes written.
//   Gaps and holds
//     - No grant outside IDLE: the earliest next grant is T+2+RL for a read, T+2 for a write.
//     - mem_addr_out holds the last granted address until the next grant.
//   Arbitration (IDLE only)
//     - Single requester: that requester wins.
//     - Both requesting: D wins unless streak==STARVE_LIMIT, then IF wins.
//     - streak: +1 on a D grant with if_req_in=1 (saturates); cleared on any IF grant,
//       and on a D grant with if_req_in=0.
//   Protocol rules
//     - A requester that drops req before ack is simply not served.
//     - A request raised while busy waits; ack never asserts outside IDLE.
//     - The arbiter does no address alignment checks.
// TESTING
//   1 IF read 0x100, BRAM returns 0xDEADBEEF, RL=2 -> if_ack@T, mem_addr=0x100@T+1,
//     if_rvalid & if_rdata=0xDEADBEEF@T+3 only; d_rvalid stays 0.
//   2 D write 0x204, be=0011, wdata=0x0000BEEF -> mem_write_enable=0011 & mem_data=0x0000BEEF
//     for exactly T+1; busy T+1 only; no rvalid.
//   3 IF and D both held high, all reads -> grant order D,D,D,D,IF,D,D,D,D,IF; every response
//     routed to the correct port.
//   4 IF held high alone, RL=2 -> if_ack every 4 cycles; d_ack never asserts.
//   5 D read requested at T+1 while IF read busy -> d_ack not before T+4 (first IDLE);
//     d_rvalid@T+7.
//   6 rst_n_in low at T+2 during READ -> all outputs 0 that cycle; no rvalid after release;
//     a fresh IF read then completes normally.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Single-port BRAM arbiter between instruction fetch (read-only) and the load/store unit.
// D has priority; a grant streak counter forces IF through after STARVE_LIMIT D wins.
module riscv_mem_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_ack_out,
    output logic        if_rvalid_out,
    output logic [31:0] if_rdata_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [3:0]  d_be_in,
    output logic        d_ack_out,
    output logic        d_rvalid_out,
    output logic [31:0] d_rdata_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  mem_write_enable_out,
    input  logic [31:0] mem_data_in,
    output logic        busy_out
);

    localparam int unsigned CNT_W    = $clog2(READ_LATENCY + 1);
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    RL_INIT    = CNT_W'(READ_LATENCY);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                owner_d_q, owner_d_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                grant_if, grant_d, read_done;

    // State and BRAM-facing registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            owner_d_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            owner_d_q <= owner_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
        end
    end

    // Arbitration, access sequencing and next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        owner_d_d = owner_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        read_done = 1'b0;

        case (state_q)
            IDLE: begin
                // Acks stay low while reset is held so every output reads 0
                if (rst_n_in) begin
                    if (d_req_in && (!if_req_in || (streak_q != STREAK_MAX))) begin
                        grant_d = 1'b1;
                    end else if (if_req_in) begin
                        grant_if = 1'b1;
                    end
                end

                if (grant_d) begin
                    owner_d_d = 1'b1;
                    addr_d    = d_addr_in;
                    if (!if_req_in) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    if (d_we_in) begin
                        wdata_d = d_wdata_in;
                        be_d    = d_be_in;
                        state_d = WRITE;
                    end else begin
                        cnt_d   = RL_INIT;
                        state_d = READ;
                    end
                end else if (grant_if) begin
                    owner_d_d = 1'b0;
                    addr_d    = if_addr_in;
                    streak_d  = '0;
                    cnt_d     = RL_INIT;
                    state_d   = READ;
                end
            end

            READ: begin
                if (cnt_q == '0) begin
                    read_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            WRITE: begin
                // Strobes live for exactly one cycle
                wdata_d = '0;
                be_d    = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_ack_out           = grant_if;
    assign d_ack_out            = grant_d;
    assign if_rvalid_out        = read_done & ~owner_d_q;
    assign d_rvalid_out         = read_done & owner_d_q;
    assign if_rdata_out         = if_rvalid_out ? mem_data_in : 32'h0;
    assign d_rdata_out          = d_rvalid_out ? mem_data_in : 32'h0;
    assign mem_addr_out         = addr_q;
    assign mem_data_out         = wdata_q;
    assign mem_write_enable_out = be_q;
    assign busy_out             = (state_q != IDLE);

endmodule
